// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared types, BCD constants and the preset sanitizer for the
//               clock / countdown timer designs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // Two-digit BCD field, {tens, ones}.
    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_59 = 8'h59;
    localparam bcd2_t BCD_00 = 8'h00;

    // Any non-BCD digit or a value above the limit clamps to the limit.
    // Valid BCD orders the same as binary, so one compare covers both fields.
    function automatic bcd2_t sanitize_bcd2(input bcd2_t value, input bcd2_t limit);
        if (value[7:4] > 4'd9 || value[3:0] > 4'd9 || value > limit)
            sanitize_bcd2 = limit;
        else
            sanitize_bcd2 = value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
// Module      : bcd_down_digit
// Description : One decrementing BCD digit with borrow; wraps 0 -> MOD-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_digit #(
    parameter int MOD = 10
) (
    input  logic [3:0] digit,
    input  logic       dec,
    output logic [3:0] next_digit,
    output logic       borrow
);

    localparam logic [3:0] c_top = 4'(MOD - 1);

    always_comb begin
        borrow     = dec && (digit == 4'd0);
        next_digit = digit;
        if (dec) begin
            if (digit == 4'd0)
                next_digit = c_top;
            else
                next_digit = digit - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_bcd.sv
// ============================================================================
// Module      : countdown_timer_bcd
// Description : Loadable MM:SS BCD countdown timer driven by a 1 Hz strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer_bcd
    import clock_pkg::*;
#(
    parameter bcd2_t MAX_MIN = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       expired_pulse
);

    timer_state_t r_state;
    bcd2_t        r_min;
    bcd2_t        r_sec;
    logic         r_running;
    logic         r_expired;
    logic         r_pulse;

    bcd2_t w_min_nxt;
    bcd2_t w_sec_nxt;
    logic  w_b0, w_b1, w_b2, w_b3;
    logic  w_dec;
    logic  w_value_zero;
    logic  w_next_zero;

    // Higher-priority load/stop suppress the tick's decrement.
    assign w_dec        = (r_state == RUN) && tick && !load && !stop;
    assign w_value_zero = (r_min == BCD_00) && (r_sec == BCD_00);
    assign w_next_zero  = (w_min_nxt == BCD_00) && (w_sec_nxt == BCD_00) && !w_b3;

    bcd_down_digit #(.MOD(10)) u_sec_ones (
        .digit(r_sec[3:0]), .dec(w_dec), .next_digit(w_sec_nxt[3:0]), .borrow(w_b0)
    );
    bcd_down_digit #(.MOD(6)) u_sec_tens (
        .digit(r_sec[7:4]), .dec(w_b0), .next_digit(w_sec_nxt[7:4]), .borrow(w_b1)
    );
    bcd_down_digit #(.MOD(10)) u_min_ones (
        .digit(r_min[3:0]), .dec(w_b1), .next_digit(w_min_nxt[3:0]), .borrow(w_b2)
    );
    bcd_down_digit #(.MOD(10)) u_min_tens (
        .digit(r_min[7:4]), .dec(w_b2), .next_digit(w_min_nxt[7:4]), .borrow(w_b3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_min     <= BCD_00;
            r_sec     <= BCD_00;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (load) begin
                r_min     <= sanitize_bcd2(preset_min, MAX_MIN);
                r_sec     <= sanitize_bcd2(preset_sec, BCD_59);
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, PAUSE: begin
                        if (start && !w_value_zero) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end else if (tick) begin
                            r_min <= w_min_nxt;
                            r_sec <= w_sec_nxt;
                            if (w_next_zero) begin
                                r_state   <= DONE;
                                r_running <= 1'b0;
                                r_expired <= 1'b1;
                                r_pulse   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // DONE holds 00:00 until load or reset.
                    end
                endcase
            end
        end
    end

    assign min_bcd       = r_min;
    assign sec_bcd       = r_sec;
    assign running       = r_running;
    assign expired       = r_expired;
    assign expired_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_bcd.sv
// ============================================================================
// Module      : tb_countdown_timer_bcd
// Description : Scoreboard bench for countdown_timer_bcd with a seconds-count
//               reference model, directed scenarios and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer_bcd;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [7:0] preset_min = 8'h00;
    logic [7:0] preset_sec = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       expired;
    logic       expired_pulse;

    countdown_timer_bcd #(.MAX_MIN(8'h59)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .start(start), .stop(stop),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .running(running), .expired(expired), .expired_pulse(expired_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] min;
        logic [7:0] sec;
        logic       run;
        logic       exp;
        logic       pulse;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: remaining time as a plain count of seconds.
    int m_total = 0;
    bit m_run   = 0;
    bit m_done  = 0;
    bit m_pulse = 0;

    function automatic int field_value(input logic [7:0] v, input int limit);
        int t = int'(v[7:4]);
        int o = int'(v[3:0]);
        if (t > 9 || o > 9 || t * 10 + o > limit) return limit;
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t = 4'(n / 10);
        logic [3:0] o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic step(input logic rs, input logic ld, input logic st,
                        input logic sp, input logic tk,
                        input logic [7:0] pm, input logic [7:0] ps);
        obs_t e;
        @(negedge clk);
        reset = rs; load = ld; start = st; stop = sp; tick = tk;
        preset_min = pm; preset_sec = ps;
        m_pulse = 0;
        if (rs) begin
            m_total = 0; m_run = 0; m_done = 0;
        end else if (ld) begin
            m_total = field_value(pm, 59) * 60 + field_value(ps, 59);
            m_run = 0; m_done = 0;
        end else if (m_run) begin
            if (sp) begin
                m_run = 0;
            end else if (tk) begin
                m_total = m_total - 1;
                if (m_total == 0) begin
                    m_run = 0; m_done = 1; m_pulse = 1;
                end
            end
        end else if (!m_done && st && m_total != 0) begin
            m_run = 1;
        end
        e.min   = to_bcd(m_total / 60);
        e.sec   = to_bcd(m_total % 60);
        e.run   = m_run;
        e.exp   = m_done;
        e.pulse = m_pulse;
        exp_q.push_back(e);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 8'h00, 8'h00);
    endtask

    task automatic do_load(input logic [7:0] pm, input logic [7:0] ps);
        step(0, 1, 0, 0, 0, pm, ps);
    endtask

    task automatic do_start();
        step(0, 0, 1, 0, 0, 8'h00, 8'h00);
    endtask

    // Monitor: the DUT presents a fresh output every cycle.
    always @(posedge clk) begin
        obs_t e;
        obs_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {min_bcd, sec_bcd, running, expired, expired_pulse};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs @%0t: actual %h:%h run=%b exp=%b pulse=%b, required %h:%h run=%b exp=%b pulse=%b",
                         $time, a.min, a.sec, a.run, a.exp, a.pulse,
                         e.min, e.sec, e.run, e.exp, e.pulse);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        nop(2);

        // 01:05 down through the minute boundary
        do_load(8'h01, 8'h05);
        do_start();
        ticks(6);
        nop(1);

        // Expiry, then a tick in DONE
        do_load(8'h00, 8'h02);
        do_start();
        ticks(3);
        nop(2);

        // stop beats a simultaneous tick; ticks in PAUSE are ignored
        do_load(8'h00, 8'h10);
        do_start();
        ticks(3);
        step(0, 0, 0, 1, 1, 8'h00, 8'h00);
        ticks(2);
        do_start();
        ticks(1);

        // Sanitizer
        do_load(8'h00, 8'h7A);
        nop(1);
        do_load(8'h99, 8'h30);
        nop(1);
        do_load(8'h3F, 8'h0C);
        nop(1);

        // Start at 00:00 is ignored; load out of DONE
        do_load(8'h00, 8'h00);
        do_start();
        nop(1);
        do_load(8'h00, 8'h01);
        do_start();
        ticks(1);
        do_load(8'h00, 8'h05);
        nop(1);

        // Reset mid-run together with a tick
        do_load(8'h00, 8'h31);
        do_start();
        ticks(1);
        step(1, 0, 0, 0, 1, 8'h00, 8'h00);
        nop(2);

        // Random commands, biased toward short presets so expiry occurs
        for (int i = 0; i < 4000; i++) begin
            logic rs, ld, st, sp, tk;
            logic [7:0] pm, ps;
            rs = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 99) < 3);
            st = ($urandom_range(0, 99) < 10);
            sp = ($urandom_range(0, 99) < 4);
            tk = ($urandom_range(0, 99) < 45);
            case ($urandom_range(0, 3))
                0:       pm = 8'h00;
                1:       pm = 8'h01;
                default: pm = 8'($urandom);
            endcase
            ps = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            step(rs, ld, st, sp, tk, pm, ps);
        end
        nop(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
